// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly-schedule sequencer: ROM word
// layout, sequencer states and the decoded operation record.
package ntt_pkg;

    localparam int ROM_W      = 64;
    localparam int OP_ENTRY_W = ROM_W + 1;   // ROM word plus the last-op flag

    // ROM word field layout
    localparam int AUX_CONST_LSB = 48;
    localparam int AUX_CONST_W   = 16;
    localparam int AUX_IDX0_LSB  = 40;
    localparam int AUX_IDX0_W    = 8;
    localparam int AUX_IDX1_LSB  = 32;
    localparam int AUX_IDX1_W    = 8;
    localparam int TWIDDLE_LSB   = 16;
    localparam int TWIDDLE_W     = 16;
    localparam int IDX_A_LSB     = 8;
    localparam int IDX_A_W       = 8;
    localparam int IDX_B_LSB     = 0;
    localparam int IDX_B_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [AUX_CONST_W-1:0] aux_const;
        logic [AUX_IDX0_W-1:0]  aux_idx0;
        logic [AUX_IDX1_W-1:0]  aux_idx1;
        logic [TWIDDLE_W-1:0]   twiddle;
        logic [IDX_A_W-1:0]     idx_a;
        logic [IDX_B_W-1:0]     idx_b;
    } bf_op_t;

    // Split a raw schedule word into its butterfly fields.
    function automatic bf_op_t decode_op(input logic [ROM_W-1:0] word);
        bf_op_t op;
        op.aux_const = word[AUX_CONST_LSB +: AUX_CONST_W];
        op.aux_idx0  = word[AUX_IDX0_LSB  +: AUX_IDX0_W];
        op.aux_idx1  = word[AUX_IDX1_LSB  +: AUX_IDX1_W];
        op.twiddle   = word[TWIDDLE_LSB   +: TWIDDLE_W];
        op.idx_a     = word[IDX_A_LSB     +: IDX_A_W];
        op.idx_b     = word[IDX_B_LSB     +: IDX_B_W];
        return op;
    endfunction

endpackage

// File: rtl/ntt_op_skid_buf.sv
// Two-entry FIFO holding fetched schedule words (plus last flag) so the
// sequencer can absorb butterfly back-pressure without losing ROM reads.
module ntt_op_skid_buf
    import ntt_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push_i,
    input  logic [OP_ENTRY_W-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OP_ENTRY_W-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [OP_ENTRY_W-1:0] mem_q [0:1];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        pop_ok   = pop_i && (count_q != 2'd0);
        push_ok  = push_i && ((count_q != 2'd2) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Storage, pointers and occupancy; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (srst) begin
            // NOTE: the two data entries are reset as well, because the head drives module outputs that must read 0 out of reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the pre-edge values.
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ntt_rom_sequencer.sv
// Walks the butterfly-schedule ROM from entry 0 to NUM_OPS-1 and hands each
// decoded operation to the butterfly unit over a valid/ready handshake.
// Reads are issued on credit so the 2-entry buffer can never overflow.
module ntt_rom_sequencer
    import ntt_pkg::*;
#(
    parameter int NUM_OPS   = 128,
    parameter int ADDR_W    = 7,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_dout,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [7:0]        bf_idx_a,
    output logic [7:0]        bf_idx_b,
    output logic [15:0]       bf_twiddle,
    output logic [7:0]        bf_aux_idx0,
    output logic [7:0]        bf_aux_idx1,
    output logic [15:0]       bf_aux_const,
    output logic              bf_last
);

    // One extra bit so a full 128-entry pass counts to 128 without wrapping.
    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0]  OPS_CNT  = CNT_W'(NUM_OPS);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]       accept_cnt_q, accept_cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;

    logic                   issue;
    logic                   pop;
    logic                   credit_ok;
    logic [2:0]             credit_use;
    logic [1:0]             buf_count;
    logic [OP_ENTRY_W-1:0]  head;
    bf_op_t                 head_op;

    assign pop        = bf_valid && bf_ready;
    // Words already committed to the buffer once this cycle's pop is taken.
    assign credit_use = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit_ok  = credit_use < 3'(BUF_DEPTH);

    // Next-state, issue decision and counter updates.
    always_comb begin
        state_d         = state_q;
        issue_cnt_d     = issue_cnt_q;
        accept_cnt_d    = accept_cnt_q + CNT_W'(pop);
        issue           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    issue_cnt_d  = '0;
                    accept_cnt_d = '0;
                end
            end
            RUN: begin
                issue = credit_ok;
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Move on in the same cycle the final operation is taken.
                if (accept_cnt_d == OPS_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        inflight_d      = issue;
        inflight_last_d = issue && (issue_cnt_q == LAST_IDX);
    end

    // Sequencer registers; srst abandons the pass and any in-flight read.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q         <= IDLE;
            issue_cnt_q     <= '0;
            accept_cnt_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            issue_cnt_q     <= issue_cnt_d;
            accept_cnt_q    <= accept_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // The ROM answers one cycle after the read, so capture on inflight_q.
    ntt_op_skid_buf u_buf (
        .clk         (clk),
        .srst        (srst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rom_dout}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (buf_count)
    );

    assign head_op      = decode_op(head[ROM_W-1:0]);

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign rom_addr     = issue_cnt_q[ADDR_W-1:0];
    assign bf_valid     = (buf_count != 2'd0);
    assign bf_idx_a     = head_op.idx_a;
    assign bf_idx_b     = head_op.idx_b;
    assign bf_twiddle   = head_op.twiddle;
    assign bf_aux_idx0  = head_op.aux_idx0;
    assign bf_aux_idx1  = head_op.aux_idx1;
    assign bf_aux_const = head_op.aux_const;
    assign bf_last      = head[ROM_W];

endmodule

// File: tb/tb_ntt_rom_sequencer.sv
// Directed bench for ntt_rom_sequencer: a full-size instance (128 ops) and a
// short instance (4 ops), each fed by a registered ROM model.
module tb_ntt_rom_sequencer;

    localparam int NOPS  = 128;
    localparam int NOPS4 = 4;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic        bf_ready;
    logic        busy, done, bf_valid, bf_last;
    logic [6:0]  rom_addr;
    logic [63:0] rom_dout = '0;
    logic [7:0]  bf_idx_a, bf_idx_b, bf_aux_idx0, bf_aux_idx1;
    logic [15:0] bf_twiddle, bf_aux_const;

    logic        start4;
    logic        bf_ready4;
    logic        busy4, done4, bf_valid4, bf_last4;
    logic [6:0]  rom_addr4;
    logic [63:0] rom_dout4 = '0;
    logic [7:0]  bf_idx_a4, bf_idx_b4, bf_aux_idx04, bf_aux_idx14;
    logic [15:0] bf_twiddle4, bf_aux_const4;

    logic [63:0] obs_word, obs_word4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Schedule contents: entry 0 is the hand-checked word, the rest are
    // distinct per field so swaps, losses and duplicates show up.
    function automatic logic [63:0] rom_word(input int i);
        if (i == 0) begin
            return 64'h05ed004004c70004;
        end
        return {16'(16'hA000 + i), 8'(i), 8'(8'hFF - i),
                16'(16'h1000 + 3 * i), 8'(i), 8'(i + 1)};
    endfunction

    always @(posedge clk) rom_dout  <= rom_word(int'(rom_addr));
    always @(posedge clk) rom_dout4 <= rom_word(int'(rom_addr4));

    assign obs_word  = {bf_aux_const, bf_aux_idx0, bf_aux_idx1, bf_twiddle, bf_idx_a, bf_idx_b};
    assign obs_word4 = {bf_aux_const4, bf_aux_idx04, bf_aux_idx14, bf_twiddle4, bf_idx_a4, bf_idx_b4};

    ntt_rom_sequencer #(.NUM_OPS(NOPS), .ADDR_W(7), .BUF_DEPTH(2)) dut (
        .clk(clk), .srst(srst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_twiddle(bf_twiddle),
        .bf_aux_idx0(bf_aux_idx0), .bf_aux_idx1(bf_aux_idx1),
        .bf_aux_const(bf_aux_const), .bf_last(bf_last)
    );

    ntt_rom_sequencer #(.NUM_OPS(NOPS4), .ADDR_W(7), .BUF_DEPTH(2)) dut4 (
        .clk(clk), .srst(srst), .start(start4), .busy(busy4), .done(done4),
        .rom_addr(rom_addr4), .rom_dout(rom_dout4),
        .bf_valid(bf_valid4), .bf_ready(bf_ready4),
        .bf_idx_a(bf_idx_a4), .bf_idx_b(bf_idx_b4), .bf_twiddle(bf_twiddle4),
        .bf_aux_idx0(bf_aux_idx04), .bf_aux_idx1(bf_aux_idx14),
        .bf_aux_const(bf_aux_const4), .bf_last(bf_last4)
    );

    task automatic check_all_zero(input string tag);
        logic [77:0] outs;
        outs = {busy, done, rom_addr, bf_valid, obs_word, bf_last};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL %s all_outputs_zero: got %0h expected 0", tag, outs);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; bf_ready = 1'b0;
        start4 = 1'b0; bf_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        checks++;
        if ({busy4, done4, bf_valid4, rom_addr4} !== '0) begin
            errors++;
            $display("FAIL reset dut4_outputs: got %0h expected 0", {busy4, done4, bf_valid4, rom_addr4});
        end
        srst = 1'b0;
        @(negedge clk);
    endtask

    // One pass on the 128-op instance. mode 0: ready always 1 (cycle exact);
    // mode 1: random ready; mode 2: ready low for cycles 0..20, then 1.
    task automatic run_pass(input int mode, input string tag);
        int          acc;
        int          c;
        int          done_cycle;
        logic [64:0] held;
        logic        held_v;
        acc = 0; c = 0; done_cycle = -1; held_v = 1'b0; held = '0;
        start    = 1'b1;
        bf_ready = (mode == 0);
        while (done_cycle < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (done) begin
                done_cycle = c;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_on_done: got %b expected 0", tag, busy);
                end
                checks++;
                if (acc != NOPS) begin
                    errors++;
                    $display("FAIL %s accept_total: got %0d expected %0d", tag, acc, NOPS);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy c=%0d: got %b expected 1", tag, c, busy);
                end
                if (mode == 0) begin
                    checks++;
                    if (bf_valid !== (c >= 3 && c <= 130)) begin
                        errors++;
                        $display("FAIL %s valid_timing c=%0d: got %b expected %b", tag, c, bf_valid, (c >= 3 && c <= 130));
                    end
                end
                if (mode == 0 && c == 3) begin
                    checks++;
                    if ({bf_idx_a, bf_idx_b, bf_twiddle, bf_aux_idx0, bf_aux_idx1, bf_aux_const}
                        !== {8'h00, 8'h04, 16'h04c7, 8'h00, 8'h40, 16'h05ed}) begin
                        errors++;
                        $display("FAIL %s word0_fields: got a=%0h b=%0h tw=%0h x0=%0h x1=%0h k=%0h expected a=0 b=4 tw=4c7 x0=0 x1=40 k=5ed",
                                 tag, bf_idx_a, bf_idx_b, bf_twiddle, bf_aux_idx0, bf_aux_idx1, bf_aux_const);
                    end
                end
                if (mode == 2 && c == 21) begin
                    checks++;
                    if (rom_addr !== 7'd2) begin
                        errors++;
                        $display("FAIL %s stall_rom_addr: got %0d expected 2", tag, rom_addr);
                    end
                    checks++;
                    if ({bf_valid, obs_word} !== {1'b1, rom_word(0)}) begin
                        errors++;
                        $display("FAIL %s stall_head: got v=%b %0h expected v=1 %0h", tag, bf_valid, obs_word, rom_word(0));
                    end
                end
                if (held_v) begin
                    checks++;
                    if ({bf_last, obs_word} !== held) begin
                        errors++;
                        $display("FAIL %s head_stable c=%0d: got %0h expected %0h", tag, c, {bf_last, obs_word}, held);
                    end
                end
                checks++;
                if (dut.u_buf.count_o > 2'd2) begin
                    errors++;
                    $display("FAIL %s buf_count c=%0d: got %0d expected <=2", tag, c, dut.u_buf.count_o);
                end
                case (mode)
                    0:       bf_ready = 1'b1;
                    1:       bf_ready = 1'($urandom_range(0, 1));
                    default: bf_ready = (c >= 21);
                endcase
                held_v = 1'b0;
                if (bf_valid) begin
                    if (bf_ready) begin
                        checks++;
                        if ({bf_last, obs_word} !== {(acc == NOPS - 1), rom_word(acc)}) begin
                            errors++;
                            $display("FAIL %s op[%0d]: got last=%b %0h expected last=%b %0h",
                                     tag, acc, bf_last, obs_word, (acc == NOPS - 1), rom_word(acc));
                        end
                        acc++;
                    end else begin
                        held   = {bf_last, obs_word};
                        held_v = 1'b1;
                    end
                end
            end
        end
        bf_ready = 1'b0;
        checks++;
        if (done_cycle < 0) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done", tag);
        end else if (mode == 0 && done_cycle != 131) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected 131", tag, done_cycle);
        end
        @(negedge clk);
    endtask

    task automatic test_full_speed();
        run_pass(0, "full_speed");
    endtask

    task automatic test_random_ready();
        run_pass(1, "random_ready");
    endtask

    task automatic test_stall();
        run_pass(2, "stall20");
    endtask

    task automatic test_srst_abort();
        int ndone;
        ndone    = 0;
        start    = 1'b1;
        bf_ready = 1'b1;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if ({bf_valid, obs_word} !== {1'b1, rom_word(50)}) begin
            errors++;
            $display("FAIL srst head_at_50: got v=%b %0h expected v=1 %0h", bf_valid, obs_word, rom_word(50));
        end
        srst = 1'b1;
        @(negedge clk);
        check_all_zero("srst_abort");
        srst     = 1'b0;
        bf_ready = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL srst no_done_after_abort: got %0d active cycles expected 0", ndone);
        end
        run_pass(0, "replay");
    endtask

    task automatic test_restart_ignored();
        int ndone;
        ndone    = 0;
        start    = 1'b1;
        bf_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c == 132) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL restart busy_after_done: got %b expected 0", busy);
                end
            end
            start = (c == 5 || c == 60 || c == 131);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL restart done_count: got %0d expected 1", ndone);
        end
        start    = 1'b0;
        bf_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_num_ops4();
        int acc4;
        int done_cycle;
        acc4 = 0; done_cycle = -1;
        start4    = 1'b1;
        bf_ready4 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            checks++;
            if ({busy4, bf_valid4} !== {(c <= 6), (c >= 3 && c <= 6)}) begin
                errors++;
                $display("FAIL ops4 busy_valid c=%0d: got %b%b expected %b%b", c, busy4, bf_valid4, (c <= 6), (c >= 3 && c <= 6));
            end
            if (done4 && done_cycle < 0) done_cycle = c;
            if (bf_valid4 && bf_ready4) begin
                checks++;
                if ({bf_last4, obs_word4} !== {(acc4 == NOPS4 - 1), rom_word(acc4)}) begin
                    errors++;
                    $display("FAIL ops4 op[%0d]: got last=%b %0h expected last=%b %0h",
                             acc4, bf_last4, obs_word4, (acc4 == NOPS4 - 1), rom_word(acc4));
                end
                acc4++;
            end
        end
        checks++;
        if (acc4 != NOPS4) begin
            errors++;
            $display("FAIL ops4 accept_total: got %0d expected %0d", acc4, NOPS4);
        end
        checks++;
        if (done_cycle != 7) begin
            errors++;
            $display("FAIL ops4 done_cycle: got %0d expected 7", done_cycle);
        end
        bf_ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_speed();
        test_random_ready();
        test_stall();
        test_srst_abort();
        test_restart_ignored();
        test_num_ops4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_rom_sequencer.md
Name: ntt_rom_sequencer

Overview:
- Controller that walks one 128-entry, 64-bit butterfly-schedule ROM (registered output, 1-cycle read latency, no read enable) from entry 0 to NUM_OPS-1.
- Decodes each ROM word into butterfly operand indices, twiddle and auxiliary fields.
- Presents one operation per cycle to the NTT butterfly unit over a valid/ready handshake, absorbing downstream back-pressure with a 2-entry buffer.
- Sits between the top-level NTT control FSM (start/done) and the ROM plus butterfly datapath.

Parameters:
- NUM_OPS, 128, number of ROM entries issued per pass (1..128).
- ADDR_W, 7, ROM address width.
- BUF_DEPTH, 2, output buffer depth. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a pass. Ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last operation is accepted.
- rom_addr  out  ADDR_W  address to the ROM.
- rom_dout  in  64  ROM data. Valid the cycle after rom_addr is presented.
- bf_valid  out  1  operation available.
- bf_ready  in  1  butterfly accepts the operation.
- bf_idx_a  out  8  rom word [15:8].
- bf_idx_b  out  8  rom word [7:0].
- bf_twiddle  out  16  rom word [31:16].
- bf_aux_idx0  out  8  rom word [47:40].
- bf_aux_idx1  out  8  rom word [39:32].
- bf_aux_const  out  16  rom word [63:48].
- bf_last  out  1  high with the operation from entry NUM_OPS-1.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, buffer empty. srst mid-pass aborts immediately: no done pulse, and buffered or in-flight words are discarded.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: issues reads. When the issue count reaches NUM_OPS -> DRAIN.
  - DRAIN: stops issuing. When accept count = NUM_OPS -> DONE.
  - DONE: asserts done for 1 cycle -> IDLE.
  - busy=1 in RUN and DRAIN.
- Issue rule: in RUN, a read issues in a cycle iff buf_count + inflight - pop < 2.
  - pop = bf_valid & bf_ready.
  - inflight = a read was issued in the previous cycle.
  - rom_addr = issue counter, incremented on each issue. rom_addr holds its value when no read issues.
- Capture: at the end of the cycle after an issue, rom_dout is written into the buffer tail together with the bf_last flag (issued index = NUM_OPS-1). The credit rule guarantees the buffer never overflows.
- Output: bf_* are driven from the registered buffer head, not combinationally from rom_dout.
  - bf_valid = buffer non-empty.
  - Head fields are stable while bf_valid=1 and bf_ready=0.
- Simultaneous push and pop: count unchanged, order preserved.
- Latency: start in cycle 0 -> rom_addr=0 in cycle 1 -> captured at end of cycle 2 -> bf_valid=1 in cycle 3.
- Throughput: with bf_ready held 1, one operation per cycle in cycles 3..130; done pulses in cycle 131.
- start asserted in the same cycle as done, or during busy: ignored.
- Accept counter width ADDR_W+1, so NUM_OPS=128 compares without wrap.

Decomposition:
- Shared package ntt_pkg:
  - ROM word field offsets/widths (AUX_CONST 63:48, AUX_IDX0 47:40, AUX_IDX1 39:32, TWIDDLE 31:16, IDX_A 15:8, IDX_B 7:0).
  - State enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: ntt_op_skid_buf, a 2-entry 65-bit FIFO holding word plus last flag, with push/pop/count.

Test Plan:
- Reset then start with bf_ready=1 -> bf_valid first in cycle 3 with word0 fields (for word 64'h05ed004004c70004: idx_a=0x00, idx_b=0x04, twiddle=0x04c7, aux_idx0=0x00, aux_idx1=0x40, aux_const=0x05ed); 128 consecutive accepts; bf_last only on entry 127; done in cycle 131; busy cycles 1..130.
- Random bf_ready (50%) -> the 128 words arrive in address order with no loss or duplication, head stable while stalled, buffer count never exceeds 2.
- bf_ready=0 held for 20 cycles after start -> rom_addr stops advancing at 2 issues; bf_valid=1 holding word0; on release, stream resumes in order.
- srst pulsed while at entry 50 -> all outputs 0 next cycle, no done; a fresh start replays from entry 0.
- start re-pulsed while busy and on the done cycle -> ignored; exactly one done per accepted start.
- NUM_OPS=4 -> entries 0..3 only, bf_last on entry 3, done follows the 4th accept.
